// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter in front of a single-port register file.
// Round-robin on contention, registered RF command bus, fixed two-edge read return.
module reg_file_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ADDR  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic             WrA,
  input  logic             WrB,
  input  logic [ADDR-1:0]  AddrA,
  input  logic [ADDR-1:0]  AddrB,
  input  logic [WIDTH-1:0] WrDataA,
  input  logic [WIDTH-1:0] WrDataB,
  output logic             GntA,
  output logic             GntB,
  output logic             RdValidA,
  output logic             RdValidB,
  output logic [WIDTH-1:0] RdData,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD_A = 2'd1,
    CMD_B = 2'd2
  } arbStateT;

  arbStateT state;
  arbStateT nextState;
  logic     ptrB;       // 1 when B holds priority on contention
  logic     rdReturnA;
  logic     rdReturnB;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state follows whoever is granted this cycle
  always_comb begin
    nextState = IDLE;
    if (GntA) begin
      nextState = CMD_A;
    end else if (GntB) begin
      nextState = CMD_B;
    end
  end

  // Grants plus read-return decode of the command currently on the RF bus
  always_comb begin
    GntA      = 1'b0;
    GntB      = 1'b0;
    rdReturnA = 1'b0;
    rdReturnB = 1'b0;
    if (rst) begin
      GntA = ReqA & (~ReqB | ~ptrB);
      GntB = ReqB & (~ReqA |  ptrB);
    end
    case (state)
      CMD_A:   rdReturnA = RF_RdEn;
      CMD_B:   rdReturnB = RF_RdEn;
      default: ;
    endcase
  end

  // Priority pointer and registered RF command / read-valid outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptrB       <= 1'b0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      RdValidA   <= 1'b0;
      RdValidB   <= 1'b0;
    end else begin
      RdValidA <= rdReturnA;
      RdValidB <= rdReturnB;
      RF_WrEn  <= 1'b0;
      RF_RdEn  <= 1'b0;
      if (GntA) begin
        ptrB       <= 1'b1;
        RF_WrEn    <= WrA;
        RF_RdEn    <= ~WrA;
        RF_Address <= AddrA;
        RF_WrData  <= WrDataA;
      end else if (GntB) begin
        ptrB       <= 1'b0;
        RF_WrEn    <= WrB;
        RF_RdEn    <= ~WrB;
        RF_Address <= AddrB;
        RF_WrData  <= WrDataB;
      end
    end
  end

  assign RdData = RF_RdData;

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, data width; ADDR, default 3, address width (8 registers).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ReqA, ReqB  input  1 each  access request from requester A or B; held high with fields stable until granted.
REQ-005 WrA, WrB  input  1 each  access type: 1 = write, 0 = read.
REQ-006 AddrA, AddrB  input  ADDR each  target register.
REQ-007 WrDataA, WrDataB  input  WIDTH each  write data.
REQ-008 GntA, GntB  output  1 each  combinational grant; request accepted at the coming edge.
REQ-009 RdValidA, RdValidB  output  1 each  registered; RdData holds that requester's read result this cycle.
REQ-010 RdData  output  WIDTH  read data, passed through from RF_RdData.
REQ-011 RF_WrEn, RF_RdEn  output  1 each  registered register-file enables.
REQ-012 RF_Address  output  ADDR  registered register-file address.
REQ-013 RF_WrData  output  WIDTH  registered register-file write data.
REQ-014 RF_RdData  input  WIDTH  register-file read data; valid the cycle after the edge that sampled RF_RdEn high.

Function
REQ-015 The block SHALL issue at most one register-file command per cycle, and never RF_WrEn and RF_RdEn together.
REQ-016 FSM states SHALL be IDLE (no command on the RF bus), CMD_A (A's command on the RF bus) and CMD_B (B's command on the RF bus); the next state SHALL be the state of the requester granted this cycle, or IDLE if none is granted.
REQ-017 A single requester SHALL be granted whenever it requests alone, every cycle, giving back-to-back throughput.
REQ-018 With ReqA and ReqB both high, the grant SHALL go to the requester holding priority: a 1-bit round-robin pointer.
REQ-019 The pointer SHALL move to the non-granted requester after every grant and stay unchanged in cycles with no grant.
REQ-020 GntX SHALL equal ReqX AND (other not requesting OR pointer selects X); GntA and GntB SHALL never both be high.
REQ-021 At the edge ending a GntX cycle, the block SHALL register the RF command:
- RF_WrEn = WrX, RF_RdEn = NOT WrX
- RF_Address = AddrX, RF_WrData = WrDataX
REQ-022 In a cycle with no grant, RF_WrEn and RF_RdEn SHALL be 0 at the next edge; RF_Address and RF_WrData SHALL hold their values.
REQ-023 Read latency SHALL be fixed at 2 edges from grant:
- Grant seen at edge N; command on the RF bus in cycle N to N+1.
- At edge N+1 the RF updates its data and RdValidX is set for exactly one cycle.
- RdData is valid during that cycle.
REQ-024 A write SHALL produce no RdValid pulse; write completion is implied by the grant.
REQ-025 A read issued in the cycle after a write to the same address SHALL return the newly written data; the RF sequencing guarantees this, and the block adds no bypass.
REQ-026 RdValidA and RdValidB SHALL never both be high; pipelined reads from alternating requesters SHALL produce RdValid pulses in grant order, one per cycle.
REQ-027 Deasserting ReqX in the same cycle as GntX SHALL not cancel the access; the request is already accepted.

Reset
REQ-028 While rst is sampled low, all outputs of the block SHALL go to these values at that edge, and in-flight reads SHALL be discarded with no RdValid pulse:
- FSM = IDLE, pointer = A
- RF_WrEn = RF_RdEn = 0, RF_Address = 0, RF_WrData = 0
- RdValidA = RdValidB = 0
REQ-029 GntA and GntB SHALL be forced to 0 while rst is low.
REQ-030 A request held through reset SHALL be granted in the first cycle after rst is sampled high.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset: rst low for 2 edges with ReqA = 1 -> no grant, RF enables 0, RdValid 0; GntA = 1 in the first cycle after release.
- A writes then reads: A writes 16'h000B to address 3, then reads address 3 -> RF_WrEn pulse with Address 3; RdValidA pulses 2 edges after the read grant with RdData = 16'h000B.
- Contention: ReqA and ReqB held high for 4 cycles after reset -> grants A, B, A, B; pointer alternates.
- Single requester: B issues 3 back-to-back reads of addresses 1, 7, 1 (preloaded 16'h001C and 16'h0001) -> GntB high 3 cycles; RdValidB high 3 consecutive cycles with 16'h001C, 16'h0001, 16'h001C.
- Reset mid-read: rst low on the edge after GntA for a read -> RdValidA never pulses; RF_RdEn is 0 after that edge.
- Write-then-read hazard: A writes 16'h1234 to address 5 in one cycle, and B reads address 5 in the next cycle -> RdValidB with 16'h1234.
